// File: rtl/btb_resolve_ctrl.sv
// Purpose : BTB write side. Queues one prediction record per fetched instruction
//           and checks it against the EX resolution. On a mispredict it flushes
//           and redirects the front end and writes or invalidates the BTB entry.
// Latency : resolving edge -> flush/redirect_pc/btb_wr_valid visible 1 cycle later.
// Backpressure: pred_full stalls fetch. res_ready=0 holds EX while a BTB write
//           waits for btb_wr_ready. btb_wr_* is held stable until it is accepted.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   pred_push/pc/taken/target   prediction record from fetch; pred_full = queue full
//   res_valid/is_br/taken/target resolution of the oldest in-flight instruction;
//                               res_ready = resolution accepted this cycle
//   flush, redirect_pc          1-cycle squash pulse and the correct fetch PC
//   btb_wr_valid/ready/pc/target/insert  BTB write port (insert=0 means invalidate)
//   mispred_cnt                 saturating mispredict counter
//   err_underflow               sticky flag: a resolution arrived with no record queued

module btb_resolve_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              pred_push,
  input  logic [ADDR_W-1:0] pred_pc,
  input  logic              pred_taken,
  input  logic [ADDR_W-1:0] pred_target,
  output logic              pred_full,

  input  logic              res_valid,
  input  logic              res_is_br,
  input  logic              res_taken,
  input  logic [ADDR_W-1:0] res_target,
  output logic              res_ready,

  output logic              flush,
  output logic [ADDR_W-1:0] redirect_pc,

  output logic              btb_wr_valid,
  input  logic              btb_wr_ready,
  output logic [ADDR_W-1:0] btb_wr_pc,
  output logic [ADDR_W-1:0] btb_wr_target,
  output logic              btb_wr_insert,

  output logic [CNT_W-1:0]  mispred_cnt,
  output logic              err_underflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic {
    RUN     = 1'b0,
    WR_WAIT = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Record storage. The data arrays carry no reset: occupancy is
  // tracked by count, so stale entries are never read.
  logic [ADDR_W-1:0] fifo_pc     [DEPTH];
  logic [ADDR_W-1:0] fifo_target [DEPTH];
  logic [DEPTH-1:0]  fifo_taken;

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    count;

  logic              empty;
  logic              pop;
  logic              push_ok;
  logic [ADDR_W-1:0] head_pc;
  logic [ADDR_W-1:0] head_target;
  logic              head_taken;
  logic              miss_insert;
  logic              miss_inval;
  logic              mispredict;

  assign empty     = (count == '0);
  assign pred_full = (count == FULL_CNT);

  assign head_pc     = fifo_pc[rd_ptr];
  assign head_target = fifo_target[rd_ptr];
  assign head_taken  = fifo_taken[rd_ptr];

  assign pop = res_valid & res_ready & ~empty;

  // Taken branch whose direction or target was wrong: the BTB needs the real target.
  assign miss_insert = res_is_br & res_taken & (~head_taken | (head_target != res_target));
  // The BTB predicted taken but the branch fell through, or the instruction is not
  // a branch at all (an aliased entry). Either way the entry is removed.
  assign miss_inval  = head_taken & (~res_is_br | ~res_taken);
  assign mispredict  = pop & (miss_insert | miss_inval);

  // When full, a push is taken only alongside a pop, so occupancy stays at DEPTH.
  // A mispredict clears the queue, so a push in that same cycle belongs to the
  // wrong path and is dropped.
  assign push_ok = pred_push & (~pred_full | pop) & ~mispredict;

  // FSM next state and port handshakes
  always_comb begin
    state_nxt    = state;
    res_ready    = 1'b0;
    btb_wr_valid = 1'b0;
    case (state)
      RUN: begin
        res_ready = 1'b1;
        if (mispredict) state_nxt = WR_WAIT;
      end
      WR_WAIT: begin
        btb_wr_valid = 1'b1;
        if (btb_wr_ready) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Record write port
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_pc[wr_ptr]     <= pred_pc;
      fifo_target[wr_ptr] <= pred_target;
      fifo_taken[wr_ptr]  <= pred_taken;
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (mispredict) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Flush, redirect and BTB write request. btb_wr_* is loaded only on a
  // mispredict, which can only occur in RUN, so it stays stable throughout WR_WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush         <= 1'b0;
      redirect_pc   <= '0;
      btb_wr_pc     <= '0;
      btb_wr_target <= '0;
      btb_wr_insert <= 1'b0;
    end else begin
      flush <= mispredict;
      if (mispredict) begin
        redirect_pc   <= miss_insert ? res_target : head_pc + 1'b1;
        btb_wr_pc     <= head_pc;
        btb_wr_target <= miss_insert ? res_target : head_target;
        btb_wr_insert <= miss_insert;
      end
    end
  end

  // Statistics and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      mispred_cnt   <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (mispredict && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + 1'b1;
      if (res_valid && res_ready && empty)   err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_btb_resolve_ctrl.sv
// Purpose : directed bench for btb_resolve_ctrl with hand-computed expectations.
// Latency : inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Backpressure: btb_wr_ready is driven directly to exercise the write-wait path.

module tb_btb_resolve_ctrl;

  logic        clk;
  logic        rst;
  logic        pred_push;
  logic [15:0] pred_pc;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic        pred_full;
  logic        res_valid;
  logic        res_is_br;
  logic        res_taken;
  logic [15:0] res_target;
  logic        res_ready;
  logic        flush;
  logic [15:0] redirect_pc;
  logic        btb_wr_valid;
  logic        btb_wr_ready;
  logic [15:0] btb_wr_pc;
  logic [15:0] btb_wr_target;
  logic        btb_wr_insert;
  logic [15:0] mispred_cnt;
  logic        err_underflow;

  int vectors;
  int miscompares;

  btb_resolve_ctrl #(.ADDR_W(16), .DEPTH(4), .CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .pred_push     (pred_push),
    .pred_pc       (pred_pc),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .pred_full     (pred_full),
    .res_valid     (res_valid),
    .res_is_br     (res_is_br),
    .res_taken     (res_taken),
    .res_target    (res_target),
    .res_ready     (res_ready),
    .flush         (flush),
    .redirect_pc   (redirect_pc),
    .btb_wr_valid  (btb_wr_valid),
    .btb_wr_ready  (btb_wr_ready),
    .btb_wr_pc     (btb_wr_pc),
    .btb_wr_target (btb_wr_target),
    .btb_wr_insert (btb_wr_insert),
    .mispred_cnt   (mispred_cnt),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_pred_full"},  32'(pred_full),     32'd0);
    chk({pfx, "_res_ready"},  32'(res_ready),     32'd1);
    chk({pfx, "_flush"},      32'(flush),         32'd0);
    chk({pfx, "_redirect"},   32'(redirect_pc),   32'd0);
    chk({pfx, "_wr_valid"},   32'(btb_wr_valid),  32'd0);
    chk({pfx, "_wr_pc"},      32'(btb_wr_pc),     32'd0);
    chk({pfx, "_wr_target"},  32'(btb_wr_target), 32'd0);
    chk({pfx, "_wr_insert"},  32'(btb_wr_insert), 32'd0);
    chk({pfx, "_cnt"},        32'(mispred_cnt),   32'd0);
    chk({pfx, "_err"},        32'(err_underflow), 32'd0);
  endtask

  task automatic push(input logic [15:0] pc, input logic tk, input logic [15:0] tgt);
    pred_push   = 1'b1;
    pred_pc     = pc;
    pred_taken  = tk;
    pred_target = tgt;
  endtask

  task automatic resolve(input logic br, input logic tk, input logic [15:0] tgt);
    res_valid  = 1'b1;
    res_is_br  = br;
    res_taken  = tk;
    res_target = tgt;
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    pred_push    = 1'b0;
    pred_pc      = '0;
    pred_taken   = 1'b0;
    pred_target  = '0;
    res_valid    = 1'b0;
    res_is_br    = 1'b0;
    res_taken    = 1'b0;
    res_target   = '0;
    btb_wr_ready = 1'b1;
    tick();
    tick();
    chk_reset("rst");
    rst = 1'b0;

    // T1: not-taken prediction, branch actually taken -> insert(0010,0040).
    // A push in the resolving cycle belongs to the wrong path and must be dropped.
    push(16'h0010, 1'b0, 16'h0000);
    tick();
    push(16'h0099, 1'b0, 16'h0000);
    resolve(1'b1, 1'b1, 16'h0040);
    tick();
    pred_push = 1'b0;
    res_valid = 1'b0;
    chk("t1_flush",     32'(flush),         32'd1);
    chk("t1_redirect",  32'(redirect_pc),   32'h0040);
    chk("t1_wr_valid",  32'(btb_wr_valid),  32'd1);
    chk("t1_wr_pc",     32'(btb_wr_pc),     32'h0010);
    chk("t1_wr_target", 32'(btb_wr_target), 32'h0040);
    chk("t1_wr_insert", 32'(btb_wr_insert), 32'd1);
    chk("t1_cnt",       32'(mispred_cnt),   32'd1);
    chk("t1_res_ready", 32'(res_ready),     32'd0);
    tick();
    chk("t1_flush_off", 32'(flush),         32'd0);
    chk("t1_wr_done",   32'(btb_wr_valid),  32'd0);
    chk("t1_ready_back",32'(res_ready),     32'd1);

    // T2: taken prediction, branch falls through -> invalidate(0020), redirect 0021.
    // If 0099 had been kept it would be the head and cause no mispredict here.
    push(16'h0020, 1'b1, 16'h0050);
    tick();
    pred_push = 1'b0;
    resolve(1'b1, 1'b0, 16'h0000);
    tick();
    res_valid    = 1'b0;
    btb_wr_ready = 1'b0;
    chk("t2_flush",     32'(flush),         32'd1);
    chk("t2_redirect",  32'(redirect_pc),   32'h0021);
    chk("t2_wr_pc",     32'(btb_wr_pc),     32'h0020);
    chk("t2_wr_insert", 32'(btb_wr_insert), 32'd0);
    chk("t2_cnt",       32'(mispred_cnt),   32'd2);

    // T5: BTB stalls for 3 cycles; fetch pushes still accepted meanwhile.
    for (int i = 0; i < 3; i++) begin
      if (i == 0) push(16'h0030, 1'b1, 16'h0060);
      else        pred_push = 1'b0;
      tick();
      chk("t5_wr_valid",  32'(btb_wr_valid),  32'd1);
      chk("t5_res_ready", 32'(res_ready),     32'd0);
      chk("t5_wr_pc",     32'(btb_wr_pc),     32'h0020);
      chk("t5_wr_insert", 32'(btb_wr_insert), 32'd0);
      chk("t5_flush",     32'(flush),         32'd0);
    end
    pred_push    = 1'b0;
    btb_wr_ready = 1'b1;
    tick();
    chk("t5_release_valid", 32'(btb_wr_valid), 32'd0);
    chk("t5_release_ready", 32'(res_ready),    32'd1);

    // T3: record pushed during WR_WAIT (0030 taken ->0060) resolves correctly.
    resolve(1'b1, 1'b1, 16'h0060);
    tick();
    res_valid = 1'b0;
    chk("t3_flush",     32'(flush),        32'd0);
    chk("t3_wr_valid",  32'(btb_wr_valid), 32'd0);
    chk("t3_cnt",       32'(mispred_cnt),  32'd2);
    chk("t3_res_ready", 32'(res_ready),    32'd1);

    // T2b: aliased non-branch at FFFF predicted taken -> redirect wraps to 0000.
    push(16'hFFFF, 1'b1, 16'h1234);
    tick();
    pred_push = 1'b0;
    resolve(1'b0, 1'b0, 16'h0000);
    tick();
    res_valid = 1'b0;
    chk("t2b_flush",     32'(flush),         32'd1);
    chk("t2b_redirect",  32'(redirect_pc),   32'h0000);
    chk("t2b_wr_pc",     32'(btb_wr_pc),     32'hFFFF);
    chk("t2b_wr_insert", 32'(btb_wr_insert), 32'd0);
    chk("t2b_cnt",       32'(mispred_cnt),   32'd3);
    tick();
    chk("t2b_wr_done",   32'(btb_wr_valid),  32'd0);

    // T4: fill with 4 not-taken records, push while full is dropped,
    // push+pop while full keeps occupancy at 4.
    for (int i = 1; i <= 4; i++) begin
      push(16'(i), 1'b0, 16'h0000);
      tick();
    end
    pred_push = 1'b0;
    chk("t4_full", 32'(pred_full), 32'd1);
    push(16'h0005, 1'b1, 16'h0055);
    tick();
    chk("t4_full_hold", 32'(pred_full), 32'd1);
    push(16'h0006, 1'b0, 16'h0000);
    resolve(1'b0, 1'b0, 16'h0000);
    tick();
    pred_push = 1'b0;
    chk("t4_pushpop_full",  32'(pred_full), 32'd1);
    chk("t4_pushpop_flush", 32'(flush),     32'd0);
    tick();
    chk("t4_pop2_full",  32'(pred_full), 32'd0);
    chk("t4_pop2_flush", 32'(flush),     32'd0);
    tick();
    chk("t4_pop3_flush", 32'(flush),     32'd0);
    tick();
    chk("t4_pop4_flush", 32'(flush),     32'd0);
    // Remaining head must be 0006 (not-taken): actual taken to 0077 -> insert(0006,0077).
    resolve(1'b1, 1'b1, 16'h0077);
    tick();
    res_valid = 1'b0;
    chk("t4_last_flush",    32'(flush),         32'd1);
    chk("t4_last_redirect", 32'(redirect_pc),   32'h0077);
    chk("t4_last_wr_pc",    32'(btb_wr_pc),     32'h0006);
    chk("t4_last_insert",   32'(btb_wr_insert), 32'd1);
    chk("t4_last_cnt",      32'(mispred_cnt),   32'd4);
    tick();

    // T6: resolution with an empty queue sets a sticky error, then reset in WR_WAIT.
    resolve(1'b0, 1'b0, 16'h0000);
    tick();
    res_valid = 1'b0;
    chk("t6_err",        32'(err_underflow), 32'd1);
    chk("t6_err_flush",  32'(flush),         32'd0);
    tick();
    chk("t6_err_sticky", 32'(err_underflow), 32'd1);
    push(16'h0040, 1'b0, 16'h0000);
    tick();
    pred_push    = 1'b0;
    btb_wr_ready = 1'b0;
    resolve(1'b1, 1'b1, 16'h0088);
    tick();
    res_valid = 1'b0;
    chk("t6_wrwait_valid", 32'(btb_wr_valid), 32'd1);
    chk("t6_wrwait_ready", 32'(res_ready),    32'd0);
    chk("t6_wrwait_cnt",   32'(mispred_cnt),  32'd5);
    rst = 1'b1;
    tick();
    chk_reset("t6_rst");
    rst          = 1'b0;
    btb_wr_ready = 1'b1;
    tick();
    chk("t6_post_wr_valid", 32'(btb_wr_valid), 32'd0);
    chk("t6_post_ready",    32'(res_ready),    32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
